// File: rtl/aibio_cdr_pi_ctrl.sv
// CDR phase-interpolator controller: majority-votes synchronized early/late samples per window
// and steps the PI code (coarse ACQ, fine TRACK). Optional code override: `define AIBIO_CDR_CODE_OVRD_EN.
module aibio_cdr_pi_ctrl #(
    parameter int CODE_W   = 7,
    parameter int WIN_LOG2 = 4,
    parameter int DEADBAND = 2,
    parameter int STEP_ACQ = 4,
    parameter int STEP_TRK = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic              clk_int,
    input  logic              rstb,
    input  logic              i_cdr_phdet,
    input  logic              i_cdr_en,
    input  logic [CODE_W-1:0] i_pi_code_init,
`ifdef AIBIO_CDR_CODE_OVRD_EN
    input  logic              i_code_ovrd_en,
    input  logic [CODE_W-1:0] i_code_ovrd,
`endif
    output logic [CODE_W-1:0] o_pi_code,
    output logic              o_pi_upd,
    output logic              o_cdr_lock,
    output logic [1:0]        o_cdr_state
);

    localparam int N     = 1 << WIN_LOG2;
    localparam int UP_TH = N / 2 + DEADBAND;
    localparam int DN_TH = N / 2 - DEADBAND;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t              state;
    logic                ph_m, ph_s;
    logic [WIN_LOG2-1:0] smp_cnt;
    logic [WIN_LOG2:0]   ones_cnt, ones_sum;
    logic [LCK_W-1:0]    lock_cnt;
    logic                prev_vld, prev_up;
    logic                win_end, dec_up, dec_dn, dec_hold, reversal, same_dir;
    logic [CODE_W-1:0]   step, code_nxt;
    logic                ovrd;
    logic [CODE_W-1:0]   ovrd_code;

`ifdef AIBIO_CDR_CODE_OVRD_EN
    assign ovrd      = i_code_ovrd_en;
    assign ovrd_code = i_code_ovrd;
`else
    assign ovrd      = 1'b0;
    assign ovrd_code = '0;
`endif

    assign o_cdr_state = state;

    always_ff @(posedge clk_int or negedge rstb) begin
        if (!rstb) begin
            ph_m <= 1'b0;
            ph_s <= 1'b0;
        end else begin
            ph_m <= i_cdr_phdet;
            ph_s <= ph_m;
        end
    end

    // The final sample of a window is folded in combinationally so the vote covers all N samples.
    always_comb begin
        ones_sum = ones_cnt + (WIN_LOG2 + 1)'(ph_s);
        win_end  = (state != ST_IDLE) && (&smp_cnt);
        dec_up   = int'(ones_sum) >= UP_TH;
        dec_dn   = !dec_up && (int'(ones_sum) <= DN_TH);
        dec_hold = !dec_up && !dec_dn;
        reversal = prev_vld && ((dec_up && !prev_up) || (dec_dn && prev_up));
        same_dir = prev_vld && ((dec_up && prev_up) || (dec_dn && !prev_up));
        step     = (state == ST_ACQ) ? CODE_W'(STEP_ACQ) : CODE_W'(STEP_TRK);
        code_nxt = dec_up ? o_pi_code + step : o_pi_code - step;
    end

    always_ff @(posedge clk_int or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_IDLE;
            smp_cnt    <= '0;
            ones_cnt   <= '0;
            lock_cnt   <= '0;
            prev_vld   <= 1'b0;
            prev_up    <= 1'b0;
            o_pi_code  <= '0;
            o_pi_upd   <= 1'b0;
            o_cdr_lock <= 1'b0;
        end else begin
            o_pi_upd <= 1'b0;
            if (state == ST_IDLE || !i_cdr_en) begin
                smp_cnt    <= '0;
                ones_cnt   <= '0;
                lock_cnt   <= '0;
                prev_vld   <= 1'b0;
                o_cdr_lock <= 1'b0;
                if (state == ST_IDLE && i_cdr_en) begin
                    state     <= ST_ACQ;
                    o_pi_code <= i_pi_code_init;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (!win_end) begin
                smp_cnt  <= smp_cnt + WIN_LOG2'(1);
                ones_cnt <= ones_sum;
            end else begin
                smp_cnt  <= '0;
                ones_cnt <= '0;
                if (!dec_hold) begin
                    prev_vld  <= 1'b1;
                    prev_up   <= dec_up;
                    o_pi_code <= code_nxt;
                    o_pi_upd  <= 1'b1;
                end
                if (state == ST_ACQ) begin
                    if (dec_hold || reversal)
                        state <= ST_TRACK;
                end else if (same_dir) begin
                    lock_cnt   <= '0;
                    o_cdr_lock <= 1'b0;
                end else if (dec_hold || reversal) begin
                    if (lock_cnt != LCK_W'(LOCK_CNT))
                        lock_cnt <= lock_cnt + LCK_W'(1);
                    if (lock_cnt >= LCK_W'(LOCK_CNT - 1))
                        o_cdr_lock <= 1'b1;
                end
            end
            // Override owns the code; the loop keeps voting and moving state underneath.
            if (ovrd) begin
                o_pi_code  <= ovrd_code;
                o_pi_upd   <= 1'b0;
                o_cdr_lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aibio_cdr_pi_ctrl.sv
// Bench for aibio_cdr_pi_ctrl: directed and random phase-detector stimulus checked
// every cycle against a window-level reference model.
module tb_aibio_cdr_pi_ctrl;
  localparam int CODE_W   = 7;
  localparam int WIN_LOG2 = 4;
  localparam int N        = 16;
  localparam int DEADBAND = 2;
  localparam int STEP_ACQ = 4;
  localparam int STEP_TRK = 1;
  localparam int LOCK_CNT = 4;

  logic              clk_int = 1'b0;
  logic              rstb;
  logic              i_cdr_phdet;
  logic              i_cdr_en;
  logic [CODE_W-1:0] i_pi_code_init;
  logic [CODE_W-1:0] o_pi_code;
  logic              o_pi_upd;
  logic              o_cdr_lock;
  logic [1:0]        o_cdr_state;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int m_state, m_code, m_upd, m_lock, m_lcnt, m_prev;
  int sync_q[$];
  int win_q[$];

  always #5 clk_int = ~clk_int;

  aibio_cdr_pi_ctrl #(
    .CODE_W(CODE_W), .WIN_LOG2(WIN_LOG2), .DEADBAND(DEADBAND),
    .STEP_ACQ(STEP_ACQ), .STEP_TRK(STEP_TRK), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk_int(clk_int),
    .rstb(rstb),
    .i_cdr_phdet(i_cdr_phdet),
    .i_cdr_en(i_cdr_en),
    .i_pi_code_init(i_pi_code_init),
    .o_pi_code(o_pi_code),
    .o_pi_upd(o_pi_upd),
    .o_cdr_lock(o_cdr_lock),
    .o_cdr_state(o_cdr_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    check("code", 32'(o_pi_code), m_code);
    check("upd", 32'(o_pi_upd), m_upd);
    check("lock", 32'(o_cdr_lock), m_lock);
    check("state", 32'(o_cdr_state), m_state);
  endtask

  task automatic model_reset();
    m_state = 0; m_code = 0; m_upd = 0; m_lock = 0; m_lcnt = 0; m_prev = 0;
    win_q.delete();
    sync_q = '{0, 0};
  endtask

  // One clock of the loop described at window level: the detector bit seen is the one
  // driven two clocks earlier; a window is N seen bits, voted by popcount.
  task automatic model_step(input logic en, input logic ph);
    int used, ones, dir, step;
    used = sync_q.pop_front();
    sync_q.push_back(int'(ph));
    m_upd = 0;
    if (m_state == 0) begin
      win_q.delete();
      if (en) begin
        m_state = 1; m_code = int'(i_pi_code_init); m_prev = 0; m_lcnt = 0;
      end
    end else if (!en) begin
      m_state = 0; m_lock = 0; m_lcnt = 0; m_prev = 0;
      win_q.delete();
    end else begin
      win_q.push_back(used);
      if (win_q.size() == N) begin
        ones = 0;
        foreach (win_q[i]) ones = ones + win_q[i];
        win_q.delete();
        if (ones >= N / 2 + DEADBAND) dir = 1;
        else if (ones <= N / 2 - DEADBAND) dir = -1;
        else dir = 0;
        step = (m_state == 1) ? STEP_ACQ : STEP_TRK;
        if (dir != 0) begin
          m_code = (((m_code + dir * step) % 128) + 128) % 128;
          m_upd  = 1;
        end
        if (m_state == 1) begin
          if (dir == 0 || (m_prev != 0 && dir != m_prev)) m_state = 2;
        end else if (dir != 0 && dir == m_prev) begin
          m_lcnt = 0; m_lock = 0;
        end else if (dir == 0 || m_prev != 0) begin
          m_lcnt = (m_lcnt + 1 > LOCK_CNT) ? LOCK_CNT : m_lcnt + 1;
          m_lock = (m_lcnt == LOCK_CNT) ? 1 : 0;
        end
        if (dir != 0) m_prev = dir;
      end
    end
  endtask

  task automatic cycle(input logic en, input logic ph);
    i_cdr_en    = en;
    i_cdr_phdet = ph;
    @(posedge clk_int);
    model_step(en, ph);
    @(negedge clk_int);
    check_all();
  endtask

  // kind: 0 all zero, 1 all one, 2 alternating, 3 twelve ones then zeros
  task automatic window(input int kind);
    logic b;
    for (int k = 0; k < N; k++) begin
      case (kind)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = (k % 2 == 0);
        default: b = (k < 12);
      endcase
      cycle(1'b1, b);
    end
  endtask

  task automatic idle(input int n, input logic ph);
    for (int k = 0; k < n; k++) cycle(1'b0, ph);
  endtask

  task automatic random_run(input int n_win);
    int  p;
    logic en;
    for (int w = 0; w < n_win; w++) begin
      p = $urandom_range(0, 16);
      for (int k = 0; k < N; k++) begin
        en = ($urandom_range(0, 59) != 0);
        if (!en) i_pi_code_init = CODE_W'($urandom_range(0, 127));
        cycle(en, ($urandom_range(0, 15) < p));
      end
    end
  endtask

  initial begin
    rstb = 1'b0; i_cdr_en = 1'b0; i_cdr_phdet = 1'b0; i_pi_code_init = '0;
    model_reset();
    #2;
    check("reset_code", 32'(o_pi_code), 0);
    check("reset_state", 32'(o_cdr_state), 0);
    repeat (2) @(negedge clk_int);
    rstb = 1'b1;

    // coarse acquire, ph held high
    idle(3, 1'b1);
    i_pi_code_init = 7'd10;
    cycle(1'b1, 1'b1);
    check("acq_load", 32'(o_pi_code), 10);
    window(1);
    check("acq_win1", 32'(o_pi_code), 14);
    check("acq_upd1", 32'(o_pi_upd), 1);
    window(1);
    check("acq_win2", 32'(o_pi_code), 18);

    // wrap upward and downward
    idle(1, 1'b1);
    i_pi_code_init = 7'd126;
    cycle(1'b1, 1'b1);
    window(1);
    check("wrap_up", 32'(o_pi_code), 2);
    idle(3, 1'b0);
    i_pi_code_init = 7'd1;
    cycle(1'b1, 1'b0);
    window(0);
    check("wrap_dn", 32'(o_pi_code), 125);

    // UP then DN reversal into TRACK, then dither to lock
    idle(3, 1'b1);
    i_pi_code_init = 7'd40;
    cycle(1'b1, 1'b1);
    window(1);
    window(0);
    check("rev_track", 32'(o_cdr_state), 2);
    check("rev_code", 32'(o_pi_code), 40);
    for (int w = 0; w < 3; w++) window(2);
    check("prelock", 32'(o_cdr_lock), 0);
    window(2);
    check("lock_up", 32'(o_cdr_lock), 1);
    check("lock_code", 32'(o_pi_code), 40);
    window(2);
    window(3);
    check("rev_keeps_lock", 32'(o_cdr_lock), 1);
    check("trk_step1", 32'(o_pi_code), 41);
    window(3);
    check("lock_drop", 32'(o_cdr_lock), 0);
    check("trk_step2", 32'(o_pi_code), 42);
    check("drop_state", 32'(o_cdr_state), 2);

    // disable mid-window, then re-enable reloads init
    idle(1, 1'b1);
    i_pi_code_init = 7'd60;
    cycle(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    check("dis_state", 32'(o_cdr_state), 0);
    check("dis_upd", 32'(o_pi_upd), 0);
    check("dis_code", 32'(o_pi_code), 60);
    i_pi_code_init = 7'd33;
    cycle(1'b1, 1'b1);
    check("reen_code", 32'(o_pi_code), 33);

    // random traffic with an asynchronous reset in the middle
    i_pi_code_init = CODE_W'($urandom_range(0, 127));
    random_run(25);
    #2 rstb = 1'b0;
    #1;
    check("arst_code", 32'(o_pi_code), 0);
    check("arst_upd", 32'(o_pi_upd), 0);
    check("arst_lock", 32'(o_cdr_lock), 0);
    check("arst_state", 32'(o_cdr_state), 0);
    model_reset();
    @(negedge clk_int);
    rstb = 1'b1;
    random_run(25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/aibio_cdr_pi_ctrl.md
Name: aibio_cdr_pi_ctrl

Overview:
Consumer end of the CDR phase-detect path. It takes the single-bit early/late sample from the CDR phase detector, synchronizes it, and majority-votes it over fixed windows. It steps the phase-interpolator (PI) code up or down, with a coarse-acquire mode and a fine-track mode. It flags lock once the loop dithers around the sampling point, and sits between the phase detector and the RX PI code input.

Parameters:
CODE_W, 7, PI code width; code space is circular, modulo 2^CODE_W.
WIN_LOG2, 4, vote window length N = 2^WIN_LOG2 samples.
DEADBAND, 2, half-width of the no-move band around N/2.
STEP_ACQ, 4, code step per decision in ACQ state.
STEP_TRK, 1, code step per decision in TRACK state.
LOCK_CNT, 4, number of consecutive qualifying windows required to assert lock.

Ports:
clk_int  input  1  block clock; the PI sampling clock domain.
rstb  input  1  asynchronous, active-low reset.
i_cdr_phdet  input  1  phase-detector sample; asynchronous to clk_int, so synchronized internally.
i_cdr_en  input  1  loop enable (level).
i_pi_code_init  input  CODE_W  code loaded on ACQ entry.
o_pi_code  output  CODE_W  PI code, registered.
o_pi_upd  output  1  one-cycle pulse when o_pi_code changes.
o_cdr_lock  output  1  lock indicator, registered.
o_cdr_state  output  2  current state: 0=IDLE, 1=ACQ, 2=TRACK.

Behaviour:
- Reset (rstb=0, async):
  - o_pi_code=0, o_pi_upd=0, o_cdr_lock=0, state=IDLE.
  - Sync flops, sample counter and ones counter all cleared.
- Synchronizer: two-flop synchronizer on i_cdr_phdet (reset 0). The synchronized output is ph_s.
- IDLE:
  - Counters held at 0; o_pi_code held.
  - When i_cdr_en=1 is sampled: next state ACQ; o_pi_code <= i_pi_code_init on the same edge; o_pi_upd is not pulsed.
- Window accumulation (ACQ/TRACK):
  - The sample counter (WIN_LOG2 bits) increments every cycle, starting at 0 on state entry.
  - The ones counter (WIN_LOG2+1 bits) adds ph_s every cycle.
  - When the sample counter reaches N-1, that cycle's ph_s is included and the decision is taken on that edge. Both counters restart at 0 on the same edge.
- Decision on the final ones count:
  - ones >= N/2+DEADBAND -> UP.
  - ones <= N/2-DEADBAND -> DN.
  - otherwise HOLD.
- Code update:
  - UP adds step, DN subtracts step. step = STEP_ACQ in ACQ, STEP_TRK in TRACK.
  - Arithmetic is modulo 2^CODE_W; wrap is required, no saturation.
  - o_pi_code and o_pi_upd update on the decision edge, so the code is visible the cycle after the N-th sample.
  - HOLD: no code change, no pulse.
- State and lock transitions:
  - ACQ -> TRACK on a HOLD decision, or on a decision opposite to the previous non-HOLD decision. The code update for that window still uses STEP_ACQ.
  - TRACK, lock counter: increments on HOLD or on a direction reversal; saturates at LOCK_CNT. o_cdr_lock=1 once it equals LOCK_CNT.
  - TRACK, loss of lock: a non-HOLD decision with the same direction as the previous non-HOLD decision clears the lock counter and o_cdr_lock on that edge. State stays TRACK.
  - Previous direction is cleared on ACQ entry; the first non-HOLD decision never counts as a reversal.
- i_cdr_en=0 in any state:
  - Next edge: state=IDLE, o_cdr_lock=0, all counters cleared.
  - o_pi_code held. Any window in progress is discarded with no update.
- Re-enable always reloads i_pi_code_init.

Optional Feature:
AIBIO_CDR_CODE_OVRD_EN: adds input i_code_ovrd_en (1 bit) and input i_code_ovrd (CODE_W).
- With the macro: while i_code_ovrd_en=1, o_pi_code = i_code_ovrd (registered). Decisions are computed but not applied, o_pi_upd=0, and o_cdr_lock is forced 0. On release, tracking continues from i_code_ovrd with the state unchanged.
- Without the macro: these ports do not exist and the loop alone controls o_pi_code.

Test Plan:
- Reset: assert rstb=0 mid-operation -> all outputs 0 and o_cdr_state=0 immediately (async).
- ACQ step: i_pi_code_init=10, i_cdr_en=1, ph held at 1 -> o_pi_code=14 with one o_pi_upd pulse at the first window end (after the sync latency plus 16 cycles), then 18 at the next window.
- Wrap: i_pi_code_init=126, ph=1 -> o_pi_code=2 after the first window. Init=1, ph=0 -> o_pi_code=125.
- Lock: after one UP window, drive 8 ones and 8 zeros per window (HOLD) -> state=TRACK. o_cdr_lock rises at the decision edge of the 4th qualifying window; o_pi_code stays unchanged.
- Loss of lock: once locked, drive two consecutive windows of 12 ones -> code +1 each window. o_cdr_lock drops at the second decision and state stays TRACK.
- Disable mid-window: i_cdr_en=0 at sample 7 -> IDLE next edge, lock 0, no o_pi_upd, code held. Re-enabling reloads init.
